// File: rtl/settings_store_pkg.sv
// Shared definitions for the settings_store flash controller: FSM states,
// CSR register map, status bit positions and control-word constants.
// Optional readback check is enabled by defining SETTINGSSTORE_VERIFY_EN.
package settings_store_pkg;

    typedef enum logic [3:0] {
        ST_LOAD,
        ST_LOADWAIT,
        ST_IDLE,
        ST_UNPROT,
        ST_ERASE,
        ST_ERPOLL,
        ST_WRITE,
        ST_WRPOLL,
`ifdef SETTINGSSTORE_VERIFY_EN
        ST_VERIFY,
        ST_VERIFYWAIT,
`endif
        ST_PROTECT
    } state_e;

    localparam logic CSR_STATUS  = 1'b0;
    localparam logic CSR_CONTROL = 1'b1;

    localparam int BUSY_LSB = 0;
    localparam int BUSY_MSB = 1;
    localparam int WS_BIT   = 3;
    localparam int ES_BIT   = 4;

    // All sectors protected, no erase requested.
    localparam logic [31:0] CTRL_PROTECT_ALL   = 32'hFFFF_FFFF;
    // All sector protects cleared, no sector erase, no page erase.
    localparam logic [31:0] CTRL_UNPROTECT_ALL = {4'hF, 5'b00000, 3'b111, 20'hFFFFF};

    // Control word that keeps sectors unprotected and erases one page.
    function automatic logic [31:0] ctrl_page_erase(input logic [19:0] page);
        return {4'hF, 5'b00000, 3'b111, page};
    endfunction

endpackage

// File: rtl/settings_store_poller.sv
// flash_status_poller: after a start pulse waits POLLDLY idle cycles, then
// reads the flash status register (fixed read latency 1) until the busy
// field is idle, and reports done together with the selected success bit
// (es when sel_es_i=1, ws otherwise).
module flash_status_poller
    import settings_store_pkg::*;
#(
    parameter int POLLDLY = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       sel_es_i,
    input  logic [4:0] status_i,
    output logic       csr_read_o,
    output logic       done_o,
    output logic       ok_o
);

    typedef enum logic [1:0] {P_IDLE, P_WAIT, P_READ, P_SAMPLE} pstate_e;

    pstate_e     state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    logic unused_status;
    assign unused_status = status_i[2];

    // Poller state and delay counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= P_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Delay, issue a status read, sample it one cycle later, repeat while busy.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_o     = 1'b0;
        ok_o       = 1'b0;
        csr_read_o = (state_q == P_READ);
        case (state_q)
            P_IDLE: begin
                if (start_i) begin
                    if (POLLDLY == 0) begin
                        state_d = P_READ;
                    end else begin
                        cnt_d   = 16'(POLLDLY);
                        state_d = P_WAIT;
                    end
                end
            end
            P_WAIT: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q <= 16'd1) state_d = P_READ;
            end
            P_READ: begin
                state_d = P_SAMPLE;
            end
            P_SAMPLE: begin
                if (status_i[BUSY_MSB:BUSY_LSB] == 2'b00) begin
                    done_o  = 1'b1;
                    ok_o    = sel_es_i ? status_i[ES_BIT] : status_i[WS_BIT];
                    state_d = P_IDLE;
                end else begin
                    state_d = P_READ;
                end
            end
            default: state_d = P_IDLE;
        endcase
    end

endmodule

// File: rtl/settings_store.sv
// settings_store: loads NWORDS settings words from flash after reset and
// writes a new set back on save_req (unprotect, page erase, word writes,
// re-protect). Define SETTINGSSTORE_VERIFY_EN to add a readback comparison
// of the written words before the settings bank is updated.
module settings_store
    import settings_store_pkg::*;
#(
    parameter int          NWORDS   = 4,
    parameter logic [11:0] BASEADDR = 12'h000,
    parameter logic [19:0] PAGEADDR = 20'h00000,
    parameter int          POLLDLY  = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  save_req,
    input  logic [32*NWORDS-1:0]  save_data,
    output logic [32*NWORDS-1:0]  settings,
    output logic                  valid,
    output logic                  busy,
    output logic                  error,
    output logic [11:0]           avmm_data_addr,
    output logic                  avmm_data_read,
    output logic                  avmm_data_write,
    output logic [31:0]           avmm_data_writedata,
    output logic [1:0]            avmm_data_burstcount,
    input  logic [31:0]           avmm_data_readdata,
    input  logic                  avmm_data_waitrequest,
    input  logic                  avmm_data_readdatavalid,
    output logic                  avmm_csr_addr,
    output logic                  avmm_csr_read,
    output logic                  avmm_csr_write,
    output logic [31:0]           avmm_csr_writedata,
    input  logic [31:0]           avmm_csr_readdata
);

    localparam logic [3:0] LAST = 4'(NWORDS - 1);

    state_e                state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic [32*NWORDS-1:0]  settings_q, settings_d;
    logic [32*NWORDS-1:0]  shadow_q, shadow_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  error_q, error_d;
    logic                  errnew_q, errnew_d;   // error raised during the current save
    logic                  drd_q, drd_d;
    logic                  dwr_q, dwr_d;
    logic [11:0]           daddr_q, daddr_d;
    logic [31:0]           dwdata_q, dwdata_d;
    logic                  cwr_q, cwr_d;
    logic [31:0]           cwdata_q, cwdata_d;

    logic poll_start, poll_rd, poll_done, poll_ok, poll_sel_es;

    logic unused_csr_hi;
    assign unused_csr_hi = ^avmm_csr_readdata[31:5];

    assign poll_sel_es = (state_q == ST_ERPOLL);

    flash_status_poller #(.POLLDLY(POLLDLY)) u_poller (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .start_i    (poll_start),
        .sel_es_i   (poll_sel_es),
        .status_i   (avmm_csr_readdata[4:0]),
        .csr_read_o (poll_rd),
        .done_o     (poll_done),
        .ok_o       (poll_ok)
    );

    // Controller state and all registered bus/output signals.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_LOAD;
            idx_q      <= '0;
            settings_q <= '0;
            shadow_q   <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b1;
            error_q    <= 1'b0;
            errnew_q   <= 1'b0;
            drd_q      <= 1'b0;
            dwr_q      <= 1'b0;
            daddr_q    <= '0;
            dwdata_q   <= '0;
            cwr_q      <= 1'b0;
            cwdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            settings_q <= settings_d;
            shadow_q   <= shadow_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
            errnew_q   <= errnew_d;
            drd_q      <= drd_d;
            dwr_q      <= dwr_d;
            daddr_q    <= daddr_d;
            dwdata_q   <= dwdata_d;
            cwr_q      <= cwr_d;
            cwdata_q   <= cwdata_d;
        end
    end

    // Next-state logic: load sequence, then save sequence on request.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        settings_d = settings_q;
        shadow_d   = shadow_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        error_d    = error_q;
        errnew_d   = errnew_q;
        drd_d      = drd_q;
        dwr_d      = dwr_q;
        daddr_d    = daddr_q;
        dwdata_d   = dwdata_q;
        cwr_d      = 1'b0;
        cwdata_d   = cwdata_q;
        // Poll delay counts from the cycle the command completes on the bus.
        poll_start = ((state_q == ST_ERPOLL) && cwr_q) ||
                     ((state_q == ST_WRITE) && dwr_q && !avmm_data_waitrequest);
        case (state_q)
            ST_LOAD: begin
                if (!drd_q) begin
                    drd_d   = 1'b1;
                    daddr_d = BASEADDR + {8'd0, idx_q};
                end else if (!avmm_data_waitrequest) begin
                    drd_d   = 1'b0;
                    state_d = ST_LOADWAIT;
                end
            end
            ST_LOADWAIT: begin
                if (avmm_data_readdatavalid) begin
                    settings_d[32*int'(idx_q) +: 32] = avmm_data_readdata;
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_IDLE: begin
                if (save_req) begin
                    shadow_d = save_data;
                    busy_d   = 1'b1;
                    errnew_d = 1'b0;
                    idx_d    = '0;
                    state_d  = ST_UNPROT;
                end
            end
            ST_UNPROT: begin
                cwr_d    = 1'b1;
                cwdata_d = CTRL_UNPROTECT_ALL;
                state_d  = ST_ERASE;
            end
            ST_ERASE: begin
                cwr_d    = 1'b1;
                cwdata_d = ctrl_page_erase(PAGEADDR);
                state_d  = ST_ERPOLL;
            end
            ST_ERPOLL: begin
                if (poll_done) begin
                    if (!poll_ok) begin
                        error_d  = 1'b1;
                        errnew_d = 1'b1;
                        state_d  = ST_PROTECT;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (!dwr_q) begin
                    dwr_d    = 1'b1;
                    daddr_d  = BASEADDR + {8'd0, idx_q};
                    dwdata_d = shadow_q[32*int'(idx_q) +: 32];
                end else if (!avmm_data_waitrequest) begin
                    dwr_d   = 1'b0;
                    state_d = ST_WRPOLL;
                end
            end
            ST_WRPOLL: begin
                if (poll_done) begin
                    if (!poll_ok) begin
                        error_d  = 1'b1;
                        errnew_d = 1'b1;
                        state_d  = ST_PROTECT;
                    end else if (idx_q == LAST) begin
                        idx_d = '0;
`ifdef SETTINGSSTORE_VERIFY_EN
                        state_d = ST_VERIFY;
`else
                        state_d = ST_PROTECT;
`endif
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_WRITE;
                    end
                end
            end
`ifdef SETTINGSSTORE_VERIFY_EN
            ST_VERIFY: begin
                if (!drd_q) begin
                    drd_d   = 1'b1;
                    daddr_d = BASEADDR + {8'd0, idx_q};
                end else if (!avmm_data_waitrequest) begin
                    drd_d   = 1'b0;
                    state_d = ST_VERIFYWAIT;
                end
            end
            ST_VERIFYWAIT: begin
                if (avmm_data_readdatavalid) begin
                    if (avmm_data_readdata != shadow_q[32*int'(idx_q) +: 32]) begin
                        error_d  = 1'b1;
                        errnew_d = 1'b1;
                    end
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        state_d = ST_PROTECT;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_VERIFY;
                    end
                end
            end
`endif
            ST_PROTECT: begin
                cwr_d    = 1'b1;
                cwdata_d = CTRL_PROTECT_ALL;
                if (!errnew_q) settings_d = shadow_q;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    assign settings             = settings_q;
    assign valid                = valid_q;
    assign busy                 = busy_q;
    assign error                = error_q;
    assign avmm_data_addr       = daddr_q;
    assign avmm_data_read       = drd_q;
    assign avmm_data_write      = dwr_q;
    assign avmm_data_writedata  = dwdata_q;
    assign avmm_data_burstcount = 2'd1;
    assign avmm_csr_addr        = cwr_q ? CSR_CONTROL : CSR_STATUS;
    assign avmm_csr_read        = poll_rd;
    assign avmm_csr_write       = cwr_q;
    assign avmm_csr_writedata   = cwdata_q;

endmodule

// File: tb/tb_settings_store.sv
// Bench for settings_store with a behavioural flash model (data + CSR ports).
module tb_settings_store;

    localparam int NW = 4;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             save_req;
    logic [32*NW-1:0] save_data;
    logic [32*NW-1:0] settings;
    logic             valid, busy, error;
    logic [11:0]      avmm_data_addr;
    logic             avmm_data_read, avmm_data_write;
    logic [31:0]      avmm_data_writedata;
    logic [1:0]       avmm_data_burstcount;
    logic [31:0]      avmm_data_readdata;
    logic             avmm_data_waitrequest, avmm_data_readdatavalid;
    logic             avmm_csr_addr, avmm_csr_read, avmm_csr_write;
    logic [31:0]      avmm_csr_writedata;
    logic [31:0]      avmm_csr_readdata;

    always #5 clock = ~clock;

    settings_store #(.NWORDS(NW), .BASEADDR(12'h000), .PAGEADDR(20'h00000), .POLLDLY(4)) dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .save_req               (save_req),
        .save_data              (save_data),
        .settings               (settings),
        .valid                  (valid),
        .busy                   (busy),
        .error                  (error),
        .avmm_data_addr         (avmm_data_addr),
        .avmm_data_read         (avmm_data_read),
        .avmm_data_write        (avmm_data_write),
        .avmm_data_writedata    (avmm_data_writedata),
        .avmm_data_burstcount   (avmm_data_burstcount),
        .avmm_data_readdata     (avmm_data_readdata),
        .avmm_data_waitrequest  (avmm_data_waitrequest),
        .avmm_data_readdatavalid(avmm_data_readdatavalid),
        .avmm_csr_addr          (avmm_csr_addr),
        .avmm_csr_read          (avmm_csr_read),
        .avmm_csr_write         (avmm_csr_write),
        .avmm_csr_writedata     (avmm_csr_writedata),
        .avmm_csr_readdata      (avmm_csr_readdata)
    );

    // ---------------- flash model ----------------
    logic [31:0] mem [16];
    logic        init_mem;
    int          waitn, wcnt;
    logic        es_fail, corrupt;
    logic        rv1, rv2;
    logic [31:0] rd1, rd2;
    int          busy_cnt;
    logic [1:0]  busy_code;
    logic        es_q, ws_q;
    int          csr_cnt, dw_cnt, erase_cnt;
    logic [31:0] csr_log [64];
    int          dw_at_csr [64];

    assign avmm_data_waitrequest   = (avmm_data_read || avmm_data_write) && (wcnt < waitn);
    assign avmm_data_readdatavalid = rv2;
    assign avmm_data_readdata      = rd2;

    initial begin
        wcnt = 0; rv1 = 0; rv2 = 0; rd1 = 0; rd2 = 0; busy_cnt = 0; busy_code = 0;
        es_q = 0; ws_q = 0; csr_cnt = 0; dw_cnt = 0; erase_cnt = 0; avmm_csr_readdata = 0;
    end

    always @(posedge clock) begin
        rv2 <= rv1;
        rd2 <= rd1;
        rv1 <= 1'b0;
        if (init_mem) begin
            for (int k = 0; k < 16; k++) mem[k] <= (k < 4) ? 32'h11111111 * (k + 1) : 32'h0;
        end
        if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        if (avmm_csr_read)
            avmm_csr_readdata <= {27'd0, es_q, ws_q, 1'b0, (busy_cnt > 0) ? busy_code : 2'b00};
        if (avmm_data_read || avmm_data_write) begin
            if (wcnt >= waitn) begin
                wcnt <= 0;
                if (avmm_data_read) begin
                    rv1 <= 1'b1;
                    rd1 <= mem[avmm_data_addr[3:0]];
                end else begin
                    mem[avmm_data_addr[3:0]] <= (corrupt && avmm_data_addr[3:0] == 4'd2) ?
                                                avmm_data_writedata ^ 32'h1 : avmm_data_writedata;
                    busy_cnt  <= 3;
                    busy_code <= 2'b10;
                    ws_q      <= 1'b1;
                    dw_cnt    <= dw_cnt + 1;
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
        if (avmm_csr_write && avmm_csr_addr == 1'b1) begin
            csr_log[csr_cnt % 64]   <= avmm_csr_writedata;
            dw_at_csr[csr_cnt % 64] <= dw_cnt;
            csr_cnt <= csr_cnt + 1;
            if (avmm_csr_writedata[19:0] != 20'hFFFFF) begin
                erase_cnt <= erase_cnt + 1;
                busy_cnt  <= 6;
                busy_code <= 2'b01;
                es_q      <= !es_fail;
                if (!es_fail) for (int k = 0; k < 16; k++) mem[k] <= 32'hFFFFFFFF;
            end
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [127:0] words;
        int           wn;
        bit           esf;
        bit           cor;
        bit           pulse;
        bit           exp_err;
        bit           exp_upd;
        int           exp_dw;
    } vec_t;

    vec_t         tbl [4];
    logic [127:0] exp_set;
    int           n, beats, csr_base, dw_base, er_base;
    logic         prev_busy;
    bit           verify_on;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef SETTINGSSTORE_VERIFY_EN
        verify_on = 1'b1;
`else
        verify_on = 1'b0;
`endif
        tbl[0] = '{words: {32'hA3, 32'hA2, 32'hA1, 32'hA0}, wn: 3, esf: 0, cor: 0, pulse: 1,
                   exp_err: 0, exp_upd: 1, exp_dw: 4};
        tbl[1] = '{words: {32'hC3, 32'hC2, 32'hC1, 32'hC0}, wn: 0, esf: 0, cor: 1, pulse: 0,
                   exp_err: verify_on, exp_upd: !verify_on, exp_dw: 4};
        tbl[2] = '{words: {32'hD3, 32'hD2, 32'hD1, 32'hD0}, wn: 1, esf: 1, cor: 0, pulse: 0,
                   exp_err: 1, exp_upd: 0, exp_dw: 0};
        tbl[3] = '{words: {32'hE3, 32'hE2, 32'hE1, 32'hE0}, wn: 2, esf: 0, cor: 0, pulse: 0,
                   exp_err: 1, exp_upd: 1, exp_dw: 4};

        reset_n = 1'b0; save_req = 1'b0; save_data = '0;
        waitn = 1; es_fail = 1'b0; corrupt = 1'b0; init_mem = 1'b1;
        repeat (3) @(negedge clock);

        // reset values
        chk("rst_settings", 128'(settings), 128'(0));
        chk("rst_valid", 128'(valid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(1));
        chk("rst_error", 128'(error), 128'(0));
        chk("rst_strobes", 128'({avmm_data_read, avmm_data_write, avmm_csr_read, avmm_csr_write}), 128'(0));
        chk("rst_addrs", 128'({avmm_data_addr, avmm_csr_addr}), 128'(0));
        chk("rst_burst", 128'(avmm_data_burstcount), 128'(1));
        chk("rst_wdata", 128'({avmm_data_writedata, avmm_csr_writedata}), 128'(0));

        // load after reset, with a save_req on the final load beat
        init_mem = 1'b0;
        reset_n  = 1'b1;
        n = 0;
        while (!avmm_data_read && n < 10) begin @(negedge clock); n++; end
        chk("first_read_latency_le2", 128'(n <= 2), 128'(1));
        beats = 0; n = 0; prev_busy = busy;
        while (!valid && n < 500) begin
            if (avmm_data_readdatavalid) begin
                beats++;
                if (beats == NW) save_req = 1'b1;
            end
            prev_busy = busy;
            @(negedge clock);
            save_req = 1'b0;
            n++;
        end
        chk("load_valid", 128'(valid), 128'(1));
        chk("load_busy_falls_with_valid", 128'({prev_busy, busy}), 128'(2'b10));
        exp_set = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        chk("load_settings", settings, exp_set);
        repeat (20) @(negedge clock);
        chk("final_beat_save_ignored_busy", 128'(busy), 128'(0));
        chk("final_beat_save_ignored_csr", 128'(csr_cnt), 128'(0));

        // table-driven saves
        for (int i = 0; i < 4; i++) begin
            waitn = tbl[i].wn; es_fail = tbl[i].esf; corrupt = tbl[i].cor;
            csr_base = csr_cnt; dw_base = dw_cnt; er_base = erase_cnt;
            save_data = tbl[i].words;
            save_req = 1'b1;
            @(negedge clock);
            save_req = 1'b0;
            chk($sformatf("v%0d_busy_rise", i), 128'(busy), 128'(1));
            if (tbl[i].pulse) begin
                n = 0;
                while (csr_cnt < csr_base + 2 && n < 200) begin @(negedge clock); n++; end
                @(negedge clock);
                save_req = 1'b1;
                @(negedge clock);
                save_req = 1'b0;
            end
            n = 0;
            while (busy && n < 3000) begin @(negedge clock); n++; end
            chk($sformatf("v%0d_done_in_time", i), 128'(n < 3000), 128'(1));
            repeat (3) @(negedge clock);
            if (tbl[i].exp_upd) exp_set = tbl[i].words;
            chk($sformatf("v%0d_settings", i), settings, exp_set);
            chk($sformatf("v%0d_error", i), 128'(error), 128'(tbl[i].exp_err));
            chk($sformatf("v%0d_busy", i), 128'(busy), 128'(0));
            chk($sformatf("v%0d_valid", i), 128'(valid), 128'(1));
            chk($sformatf("v%0d_data_writes", i), 128'(dw_cnt - dw_base), 128'(tbl[i].exp_dw));
            chk($sformatf("v%0d_csr_writes", i), 128'(csr_cnt - csr_base), 128'(3));
            chk($sformatf("v%0d_erases", i), 128'(erase_cnt - er_base), 128'(1));
            chk($sformatf("v%0d_csr_unprot", i), 128'(csr_log[csr_base % 64]), 128'(32'hF07FFFFF));
            chk($sformatf("v%0d_csr_erase", i), 128'(csr_log[(csr_base + 1) % 64]), 128'(32'hF0700000));
            chk($sformatf("v%0d_csr_protect", i), 128'(csr_log[(csr_base + 2) % 64]), 128'(32'hFFFFFFFF));
            chk($sformatf("v%0d_erase_before_writes", i),
                128'(dw_at_csr[(csr_base + 1) % 64] - dw_base), 128'(0));
            chk($sformatf("v%0d_writes_before_protect", i),
                128'(dw_at_csr[(csr_base + 2) % 64] - dw_base), 128'(tbl[i].exp_dw));
            if (tbl[i].exp_dw == 4 && !tbl[i].cor) begin
                chk($sformatf("v%0d_flash_contents", i),
                    {mem[3], mem[2], mem[1], mem[0]}, tbl[i].words);
            end
        end

        // reset asserted during the status poll of word 1
        waitn = 0; es_fail = 1'b0; corrupt = 1'b0;
        dw_base = dw_cnt;
        save_data = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
        save_req = 1'b1;
        @(negedge clock);
        save_req = 1'b0;
        n = 0;
        while (dw_cnt < dw_base + 2 && n < 2000) begin @(negedge clock); n++; end
        chk("rst_mid_reached_wrpoll1", 128'(n < 2000), 128'(1));
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_settings", 128'(settings), 128'(0));
        chk("rst_mid_valid", 128'(valid), 128'(0));
        chk("rst_mid_busy", 128'(busy), 128'(1));
        chk("rst_mid_error", 128'(error), 128'(0));
        chk("rst_mid_strobes", 128'({avmm_data_read, avmm_data_write, avmm_csr_read, avmm_csr_write}), 128'(0));
        @(negedge clock);
        reset_n = 1'b1;
        n = 0;
        while (!valid && n < 500) begin @(negedge clock); n++; end
        chk("reload_valid", 128'(valid), 128'(1));
        chk("reload_settings", settings, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF1, 32'hF0});
        chk("reload_busy", 128'(busy), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
